// File: rtl/memory_arbiter.sv
// ----------------------------------------------------------------------------
// memory_arbiter
//
// Shares the processor's single memory bus between the instruction-fetch path
// and the load/store path. Requests are served one at a time. Data requests
// win over fetches. Byte stores get their lane enables and replicated write
// data here. Byte loads come back sign-extended. A misaligned word access is
// rejected without touching the bus.
//
// Ports
//   clk, nrst                  clock, asynchronous active-low reset
//   i_read, i_addr             fetch request (held until i_done)
//   i_rdata, i_done            fetched word, one-cycle completion pulse
//   d_read, d_write, d_byte    load / store / byte-access controls
//   d_addr, d_wdata            data address and store data
//   d_rdata, d_done, d_err     load result, completion pulse, misalign pulse
//   stall                      pipeline freeze request
//   bus_read, bus_write        registered bus command
//   bus_addr, bus_wdata        word-aligned bus address, bus write data
//   bus_sel                    byte-lane enables
//   bus_rdata, bus_ack         bus read data and one-cycle completion
// ----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_done,
    input  logic              d_read,
    input  logic              d_write,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic              stall,
    output logic              bus_read,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_sel,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_I,
        WAIT_D,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Attributes of the data request being served, needed once the bus acks
    logic        req_write;
    logic        req_write_next;
    logic        req_byte;
    logic        req_byte_next;
    logic [1:0]  req_lane;
    logic [1:0]  req_lane_next;

    logic [31:0]       i_rdata_next;
    logic              i_done_next;
    logic [31:0]       d_rdata_next;
    logic              d_done_next;
    logic              d_err_next;
    logic              bus_read_next;
    logic              bus_write_next;
    logic [ADDR_W-1:0] bus_addr_next;
    logic [31:0]       bus_wdata_next;
    logic [3:0]        bus_sel_next;

    logic d_req;
    logic d_misaligned;

    // Clearing the low bits by masking (not slicing) keeps every address bit in use
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~(ADDR_W'(3));
    endfunction

    function automatic logic [31:0] sext_byte(input logic [31:0] word,
                                              input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return {{24{b[7]}}, b};
    endfunction

    assign d_req        = d_read | d_write;
    assign d_misaligned = ~d_byte & (d_addr[1:0] != 2'b00);

    // Combinational, so the pipeline freezes in the same cycle a request
    // appears. It drops only in the DONE cycle so the requester can advance.
    assign stall = ((i_read | d_read | d_write) & (state != DONE))
                 | (state == WAIT_I) | (state == WAIT_D);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            req_write <= 1'b0;
            req_byte  <= 1'b0;
            req_lane  <= 2'b00;
            i_rdata   <= '0;
            i_done    <= 1'b0;
            d_rdata   <= '0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_sel   <= '0;
        end else begin
            state     <= state_next;
            req_write <= req_write_next;
            req_byte  <= req_byte_next;
            req_lane  <= req_lane_next;
            i_rdata   <= i_rdata_next;
            i_done    <= i_done_next;
            d_rdata   <= d_rdata_next;
            d_done    <= d_done_next;
            d_err     <= d_err_next;
            bus_read  <= bus_read_next;
            bus_write <= bus_write_next;
            bus_addr  <= bus_addr_next;
            bus_wdata <= bus_wdata_next;
            bus_sel   <= bus_sel_next;
        end
    end

    // All outputs are registered. This block computes their next values, so
    // the bus command and the completion pulses start on a clean clock edge.
    always_comb begin
        state_next     = state;
        req_write_next = req_write;
        req_byte_next  = req_byte;
        req_lane_next  = req_lane;
        i_rdata_next   = i_rdata;
        i_done_next    = 1'b0;
        d_rdata_next   = d_rdata;
        d_done_next    = 1'b0;
        d_err_next     = 1'b0;
        bus_read_next  = bus_read;
        bus_write_next = bus_write;
        bus_addr_next  = bus_addr;
        bus_wdata_next = bus_wdata;
        bus_sel_next   = bus_sel;

        case (state)
            IDLE: begin
                if (d_req) begin
                    // A simultaneous read and write is served as a write
                    req_write_next = d_write;
                    req_byte_next  = d_byte;
                    req_lane_next  = d_addr[1:0];
                    if (d_misaligned) begin
                        d_err_next   = 1'b1;
                        d_rdata_next = '0;
                        state_next   = DONE;
                    end else begin
                        bus_read_next  = ~d_write;
                        bus_write_next = d_write;
                        bus_addr_next  = word_align(d_addr);
                        if (d_write && d_byte) begin
                            bus_sel_next   = 4'b0001 << d_addr[1:0];
                            bus_wdata_next = {4{d_wdata[7:0]}};
                        end else if (d_write) begin
                            bus_sel_next   = 4'hF;
                            bus_wdata_next = d_wdata;
                        end else begin
                            bus_sel_next   = 4'hF;
                            bus_wdata_next = '0;
                        end
                        state_next = WAIT_D;
                    end
                end else if (i_read) begin
                    bus_read_next  = 1'b1;
                    bus_write_next = 1'b0;
                    bus_addr_next  = word_align(i_addr);
                    bus_sel_next   = 4'hF;
                    bus_wdata_next = '0;
                    state_next     = WAIT_I;
                end
            end

            WAIT_I: begin
                if (bus_ack) begin
                    i_rdata_next   = bus_rdata;
                    i_done_next    = 1'b1;
                    bus_read_next  = 1'b0;
                    bus_write_next = 1'b0;
                    bus_addr_next  = '0;
                    bus_wdata_next = '0;
                    bus_sel_next   = '0;
                    state_next     = DONE;
                end
            end

            WAIT_D: begin
                if (bus_ack) begin
                    if (req_write) begin
                        d_rdata_next = '0;
                    end else if (req_byte) begin
                        d_rdata_next = sext_byte(bus_rdata, req_lane);
                    end else begin
                        d_rdata_next = bus_rdata;
                    end
                    d_done_next    = 1'b1;
                    bus_read_next  = 1'b0;
                    bus_write_next = 1'b0;
                    bus_addr_next  = '0;
                    bus_wdata_next = '0;
                    bus_sel_next   = '0;
                    state_next     = DONE;
                end
            end

            DONE: begin
                // Requests seen here are ignored and picked up next in IDLE
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// ----------------------------------------------------------------------------
// tb_memory_arbiter
//
// Self-checking bench for memory_arbiter. A bus responder acks after a
// programmable number of command cycles. It returns either a fixed word or a
// word derived from the bus address. Expected completions (kind + data) are
// queued when a request is driven. A monitor pops and compares them whenever
// the DUT pulses i_done, d_done or d_err. The main flow also checks bus
// command shape, stall and cycle timing.
// ----------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam int ADDR_W = 32;
    localparam int KIND_I = 0;
    localparam int KIND_D = 1;
    localparam int KIND_E = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;

    logic              clk;
    logic              nrst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_rdata;
    logic              i_done;
    logic              d_read;
    logic              d_write;
    logic              d_byte;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_done;
    logic              d_err;
    logic              stall;
    logic              bus_read;
    logic              bus_write;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_sel;
    logic [31:0]       bus_rdata;
    logic              bus_ack;

    // Responder controls and state
    int          ack_delay;
    int          cmd_count;
    logic        use_model;
    logic [31:0] resp_data;
    logic        resp_ack;
    logic [31:0] resp_rdata;
    logic        stale_ack;

    exp_t sb[$];
    exp_t mon_e;
    int   mon_kind;

    int checks_total;
    int checks_failed;

    assign bus_ack   = resp_ack | stale_ack;
    assign bus_rdata = resp_rdata;

    memory_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_byte    (d_byte),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .d_err     (d_err),
        .stall     (stall),
        .bus_read  (bus_read),
        .bus_write (bus_write),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_sel   (bus_sel),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents used by the responder in model mode
    function automatic logic [31:0] model_word(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0000;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks_total++;
        if (observed !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic sb_push(input int kind, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    // Bus responder: counts command cycles, acks in the Nth one
    initial begin
        cmd_count  = 0;
        resp_ack   = 1'b0;
        resp_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus_read || bus_write) begin
                cmd_count++;
                if (cmd_count == ack_delay) begin
                    resp_ack   = 1'b1;
                    resp_rdata = use_model ? model_word(bus_addr) : resp_data;
                end else begin
                    resp_ack = 1'b0;
                end
            end else begin
                cmd_count = 0;
                resp_ack  = 1'b0;
            end
        end
    end

    // Completion monitor: every pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (nrst && (i_done || d_done || d_err)) begin
            if (sb.size() == 0) begin
                check_output("unexpected_done", {29'b0, i_done, d_done, d_err}, 32'h0);
            end else begin
                mon_e    = sb.pop_front();
                mon_kind = i_done ? KIND_I : (d_done ? KIND_D : KIND_E);
                check_output("sb_kind", mon_kind, mon_e.kind);
                if (mon_e.kind == KIND_I) begin
                    check_output("sb_i_rdata", i_rdata, mon_e.data);
                end else if (mon_e.kind == KIND_D) begin
                    check_output("sb_d_rdata", d_rdata, mon_e.data);
                end
            end
        end
    end

    task automatic apply_stimulus(input logic rd, input logic wr, input logic byt,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        d_read  = rd;
        d_write = wr;
        d_byte  = byt;
        d_addr  = addr;
        d_wdata = wdata;
    endtask

    // Full data transaction with bus ack in the Nth command cycle
    task automatic run_data(input string tag, input logic rd, input logic wr,
                            input logic byt, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rword,
                            input int delay, input logic [3:0] exp_sel,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_result);
        use_model = 1'b0;
        resp_data = rword;
        ack_delay = delay;
        apply_stimulus(rd, wr, byt, addr, wdata);
        sb_push(KIND_D, exp_result);
        #1;
        check_output({tag, "_stall_c0"}, stall, 1);
        for (int c = 1; c <= delay; c++) begin
            @(negedge clk);
            check_output({tag, "_bus_read"}, bus_read, rd & ~wr);
            check_output({tag, "_bus_write"}, bus_write, wr);
            check_output({tag, "_bus_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
            check_output({tag, "_bus_sel"}, bus_sel, exp_sel);
            if (wr) check_output({tag, "_bus_wdata"}, bus_wdata, exp_wdata);
            check_output({tag, "_stall"}, stall, 1);
            check_output({tag, "_early_done"}, d_done, 0);
        end
        @(negedge clk);
        check_output({tag, "_d_done"}, d_done, 1);
        check_output({tag, "_cmd_off"}, {bus_read, bus_write}, 0);
        check_output({tag, "_stall_done"}, stall, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_output({tag, "_done_one_cycle"}, d_done, 0);
    endtask

    task automatic run_fetch(input string tag, input logic [31:0] addr, input int delay);
        use_model = 1'b1;
        ack_delay = delay;
        i_read    = 1'b1;
        i_addr    = addr;
        sb_push(KIND_I, model_word(addr));
        for (int c = 1; c <= delay; c++) begin
            @(negedge clk);
            check_output({tag, "_bus_read"}, bus_read, 1);
            check_output({tag, "_bus_addr"}, bus_addr, addr);
        end
        @(negedge clk);
        check_output({tag, "_i_done"}, i_done, 1);
        i_read = 1'b0;
        @(negedge clk);
        check_output({tag, "_i_done_off"}, i_done, 0);
        check_output({tag, "_i_rdata_hold"}, i_rdata, model_word(addr));
    endtask

    // Global time bound so the bench never hangs
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   budget;
        logic fetch_seen;

        checks_total  = 0;
        checks_failed = 0;
        stale_ack     = 1'b0;
        use_model     = 1'b0;
        resp_data     = '0;
        ack_delay     = 1;
        i_read        = 1'b0;
        i_addr        = '0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset values
        nrst = 1'b1;
        #2 nrst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("rst_i_rdata", i_rdata, 0);
        check_output("rst_d_rdata", d_rdata, 0);
        check_output("rst_pulses", {i_done, d_done, d_err}, 0);
        check_output("rst_bus_cmd", {bus_read, bus_write}, 0);
        check_output("rst_bus_addr", bus_addr, 0);
        check_output("rst_bus_wdata", bus_wdata, 0);
        check_output("rst_bus_sel", bus_sel, 0);
        check_output("rst_stall_idle", stall, 0);
        d_read = 1'b1;
        #1;
        check_output("rst_stall_follows", stall, 1);
        d_read = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Word load, ack in the 3rd command cycle
        run_data("word_load", 1, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3,
                 4'hF, 32'h0, 32'hDEADBEEF);
        // Byte loads with sign extension; zero-wait bus on the first
        run_data("lb_neg", 1, 0, 1, 32'h103, 32'h0, 32'h80123456, 1,
                 4'hF, 32'h0, 32'hFFFFFF80);
        run_data("lb_pos", 1, 0, 1, 32'h101, 32'h0, 32'h80123456, 2,
                 4'hF, 32'h0, 32'h00000034);
        // Stores return zero
        run_data("sb", 0, 1, 1, 32'h202, 32'h000000AB, 32'h0, 2,
                 4'b0100, 32'hABABABAB, 32'h0);
        run_data("sw", 0, 1, 0, 32'h204, 32'h12345678, 32'h0, 1,
                 4'hF, 32'h12345678, 32'h0);
        // Read and write together behave as a write
        run_data("rw_both", 1, 1, 1, 32'h301, 32'h000000C3, 32'hFFFFFFFF, 1,
                 4'b0010, 32'hC3C3C3C3, 32'h0);

        // Misaligned word store
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h106, 32'h55AA55AA);
        sb_push(KIND_E, 32'h0);
        @(negedge clk);
        check_output("mis_d_err", d_err, 1);
        check_output("mis_d_done", d_done, 0);
        check_output("mis_bus_cmd", {bus_read, bus_write}, 0);
        check_output("mis_bus_addr", bus_addr, 0);
        check_output("mis_bus_sel", bus_sel, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_output("mis_err_off", d_err, 0);
        check_output("mis_bus_write_after", bus_write, 0);

        // Simultaneous fetch and load: data first, then fetch
        use_model = 1'b1;
        ack_delay = 2;
        i_read    = 1'b1;
        i_addr    = 32'h400;
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h108, 32'h0);
        sb_push(KIND_D, model_word(32'h108));
        sb_push(KIND_I, model_word(32'h400));
        #1;
        check_output("sim_stall_c0", stall, 1);
        fetch_seen = 1'b0;
        budget     = 20;
        while (!fetch_seen && budget > 0) begin
            @(negedge clk);
            budget--;
            if (d_done || i_done) begin
                check_output("sim_stall_done", stall, 0);
            end else begin
                check_output("sim_stall_busy", stall, 1);
            end
            if (d_done) d_read = 1'b0;
            if (i_done) begin
                i_read     = 1'b0;
                fetch_seen = 1'b1;
            end
        end
        check_output("sim_fetch_timeout", fetch_seen, 1);
        @(negedge clk);
        check_output("sim_i_rdata_hold", i_rdata, model_word(32'h400));

        // Reset while waiting for a fetch ack
        use_model = 1'b1;
        ack_delay = 5;
        i_read    = 1'b1;
        i_addr    = 32'h500;
        @(negedge clk);
        @(negedge clk);
        check_output("rstmid_bus_read", bus_read, 1);
        #2;
        nrst   = 1'b0;
        i_read = 1'b0;
        #1;
        check_output("rstmid_bus_cmd", {bus_read, bus_write}, 0);
        check_output("rstmid_bus_addr", bus_addr, 0);
        check_output("rstmid_bus_sel", bus_sel, 0);
        check_output("rstmid_pulses", {i_done, d_done, d_err}, 0);
        check_output("rstmid_i_rdata", i_rdata, 0);
        check_output("rstmid_stall", stall, 0);
        @(negedge clk);
        nrst      = 1'b1;
        stale_ack = 1'b1;
        @(negedge clk);
        stale_ack = 1'b0;
        check_output("stale_i_done", i_done, 0);
        check_output("stale_bus_read", bus_read, 0);
        @(negedge clk);
        check_output("stale_i_done_late", i_done, 0);
        // FSM must be back in IDLE: a fresh zero-wait fetch completes on time
        run_fetch("post_rst_fetch", 32'h600, 1);

        repeat (2) @(negedge clk);
        check_output("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks_total, checks_failed);
        $finish;
    end

endmodule
